// File: rtl/hack_loader_pkg.sv
// Shared definitions for the HACK ROM serial loader: frame header, FSM encodings, length check.
// Optional build macro ROM_LOADER_CHECKSUM_EN adds the checksum state ST_CHK.
package hack_loader_pkg;

    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int         ADDR_W_DEF = 15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // A length is usable when it is non-zero and fits the ROM (at most 2^addr_w words).
    function automatic logic len_ok(input logic [15:0] n, input int addr_w);
        return (n != 16'd0) && ({1'b0, n} <= (17'd1 << addr_w));
    endfunction

endpackage

// File: rtl/rom_serial_loader_uart_rx.sv
// 8N1 serial receiver: 2-FF synchroniser, half-bit start confirmation, mid-bit sampling.
// byte_valid / frame_err are single-cycle pulses issued at the stop-bit sample.
module uart_rx
    import hack_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_s1_q, rx_s1_d;
    logic            rx_s2_q, rx_s2_d;
    logic            rx_prev_q, rx_prev_d;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        rx_s1_d    = rx;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A glitch shorter than half a bit falls back to idle.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    state_d    = RX_IDLE;
                    byte_valid = rx_s2_q;
                    frame_err  = !rx_s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/rom_serial_loader.sv
// Loads a HACK program image received over the AVR serial line into instruction ROM.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the last word.
module rom_serial_loader
    import hack_loader_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 500_000,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              rom_load,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              rom_we,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_rx
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    loader_state_e     state_q, state_d;
    logic              rom_load_q, rom_load_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       rom_data_q, rom_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        hi_q, hi_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]        ck_q, ck_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_load_q <= 1'b0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
            len_q      <= '0;
            hi_q       <= '0;
            timer_q    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            ck_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rom_load_q <= rom_load_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
            words_q    <= words_d;
            len_q      <= len_d;
            hi_q       <= hi_d;
            timer_q    <= timer_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            ck_q       <= ck_d;
`endif
        end
    end

    assign last_word = (17'(words_q) + 17'd1) == {1'b0, len_q};

    always_comb begin
        state_d    = state_q;
        rom_load_d = rom_load_q;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        done_d     = done_q;
        err_d      = err_q;
        words_d    = words_q;
        len_d      = len_q;
        hi_d       = hi_q;
        // Inter-byte idle time, only meaningful while a frame is open.
        timer_d    = (byte_valid || !rom_load_q) ? '0 : timer_q + 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
        ck_d       = ck_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (byte_valid && rx_byte == HDR_BYTE) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = '0;
                    rom_addr_d = '0;
                    rom_load_d = 1'b1;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (byte_valid) begin
                    hi_d    = rx_byte;
                    state_d = ST_LEN_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    ck_d    = rx_byte;
`endif
                end
            end
            ST_LEN_LO: begin
                if (byte_valid) begin
                    len_d   = {hi_q, rx_byte};
                    state_d = len_ok({hi_q, rx_byte}, ADDR_W) ? ST_DATA_HI : ST_ERR;
`ifdef ROM_LOADER_CHECKSUM_EN
                    ck_d    = ck_q + rx_byte;
`endif
                end
            end
            ST_DATA_HI: begin
                if (byte_valid) begin
                    hi_d    = rx_byte;
                    state_d = ST_DATA_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                    ck_d    = ck_q + rx_byte;
`endif
                end
            end
            ST_DATA_LO: begin
                if (byte_valid) begin
                    rom_data_d = {hi_q, rx_byte};
                    state_d    = ST_WRITE;
`ifdef ROM_LOADER_CHECKSUM_EN
                    ck_d       = ck_q + rx_byte;
`endif
                end
            end
            ST_WRITE: begin
                words_d = words_q + 1'b1;
                // A full 2^ADDR_W image leaves the address parked on the top word instead of wrapping.
                if (rom_addr_q != '1) rom_addr_d = rom_addr_q + 1'b1;
                if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA_HI;
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (byte_valid) state_d = (rx_byte == ck_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                done_d     = 1'b1;
                rom_load_d = 1'b0;
                state_d    = ST_IDLE;
            end
            ST_ERR: begin
                err_d      = 1'b1;
                rom_load_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rom_load_q && state_q != ST_DONE && state_q != ST_ERR &&
            (frame_err || (timer_q == TO_LAST && !byte_valid))) begin
            state_d = ST_ERR;
        end
    end

    assign rom_load = rom_load_q;
    assign rom_addr = rom_addr_q;
    assign rom_data = rom_data_q;
    assign rom_we   = (state_q == ST_WRITE);
    assign done     = done_q;
    assign err      = err_q;
    assign words_rx = words_q;

endmodule

// File: tb/tb_rom_serial_loader.sv
// Self-checking bench for rom_serial_loader: table vectors, hand-written corner sequences, random frames.
// Honours ROM_LOADER_CHECKSUM_EN by appending the sum byte to complete frames.
module tb_rom_serial_loader;

    localparam int CLK_HZ      = 800;
    localparam int BAUD        = 100;
    localparam int CPB         = CLK_HZ / BAUD;
    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 400;
    localparam int MAX_WORDS   = 1 << ADDR_W;
`ifdef ROM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx = 1'b1;
    logic              rom_load;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              rom_we;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_rx;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+15:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic prev_we = 1'b0;

    rom_serial_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rom_load(rom_load), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_we(rom_we), .done(done), .err(err), .words_rx(words_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest expected {addr,data} and last one cycle.
    always @(negedge clk) begin
        if (rst_n && rom_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", {rom_addr, rom_data});
            end else begin
                check("write", {rom_addr, rom_data}, exp_q.pop_front());
            end
            if (prev_we) begin
                checks++;
                errors++;
                $display("FAIL we_width actual=2+ cycles required=1");
            end
        end
        prev_we = rst_n && rom_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_tx_q();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic wait_and_check(input string name, input logic e_done, input logic e_err, input int e_words);
        int n = 0;
        while (rom_load === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_load_end"}, rom_load, 0);
        repeat (4) @(negedge clk);
        check({name, "_done"}, done, e_done);
        check({name, "_err"}, err, e_err);
        check({name, "_words"}, words_rx, e_words);
        check({name, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Outcome of a frame derived directly from the frame rules.
    function automatic void model(input int n_field, input int n_sent, input bit ck_bad,
                                  output logic e_done, output logic e_err, output int e_words);
        if (n_field == 0 || n_field > MAX_WORDS) begin
            e_done = 0; e_err = 1; e_words = 0;
        end else if (n_sent < n_field) begin
            e_done = 0; e_err = 1; e_words = n_sent;
        end else begin
            e_words = n_field;
            e_err   = CK_EN && ck_bad;
            e_done  = !e_err;
        end
    endfunction

    task automatic run_frame(input string name, input int lead, input int n_field, input int n_sent,
                             input bit ck_bad, input logic e_done, input logic e_err, input int e_words);
        logic [15:0] w;
        logic [15:0] nf;
        logic [7:0]  sum;
        bit valid;
        nf = 16'(n_field);
        valid = (n_field > 0) && (n_field <= MAX_WORDS);
        for (int k = 0; k < lead; k++) send_byte((k % 2) ? 8'hFF : 8'h00, 1'b1);
        send_byte(8'hA5, 1'b1);
        check({name, "_load_hi"}, rom_load, 1);
        tx_q.push_back(nf[15:8]);
        tx_q.push_back(nf[7:0]);
        sum = nf[15:8] + nf[7:0];
        if (valid) begin
            for (int i = 0; i < n_sent; i++) begin
                w = 16'($urandom);
                exp_q.push_back({ADDR_W'(i), w});
                tx_q.push_back(w[15:8]);
                tx_q.push_back(w[7:0]);
                sum = sum + w[15:8] + w[7:0];
            end
            if (CK_EN && n_sent == n_field) tx_q.push_back(ck_bad ? sum + 8'd1 : sum);
        end
        send_tx_q();
        wait_and_check(name, e_done, e_err, e_words);
    endtask

    typedef struct {
        int   lead;
        int   n_field;
        int   n_sent;
        bit   ck_bad;
        logic e_done;
        logic e_err;
        int   e_words;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0]  sum;
        logic        m_done, m_err;
        int          m_words, nf, ns;
        bit          cb;

        vecs[0] = '{0, 2,       2,  0, 1'b1, 1'b0, 2};
        vecs[1] = '{2, 1,       1,  0, 1'b1, 1'b0, 1};
        vecs[2] = '{0, 0,       0,  0, 1'b0, 1'b1, 0};
        vecs[3] = '{0, 3,       2,  0, 1'b0, 1'b1, 2};
        vecs[4] = '{0, 16,      16, 0, 1'b1, 1'b0, 16};
        vecs[5] = '{0, 17,      0,  0, 1'b0, 1'b1, 0};
        vecs[6] = '{1, 'h8000,  0,  0, 1'b0, 1'b1, 0};
        vecs[7] = '{0, 1,       1,  0, 1'b1, 1'b0, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rom_load", rom_load, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_rom_data", rom_data, 0);
        check("rst_rom_we", rom_we, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_words", words_rx, 0);
        rst_n = 1'b1;
        repeat (CPB * 2) @(negedge clk);

        // Literal frame A5 00 02 12 34 AB CD
        exp_q.push_back({ADDR_W'(0), 16'h1234});
        exp_q.push_back({ADDR_W'(1), 16'hABCD});
        send_byte(8'hA5, 1'b1);
        check("lit_load_hi", rom_load, 1);
        tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        sum = 8'h00 + 8'h02 + 8'h12 + 8'h34 + 8'hAB + 8'hCD;
        if (CK_EN) tx_q.push_back(sum);
        send_tx_q();
        wait_and_check("lit", 1'b1, 1'b0, 2);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("v%0d", i), vecs[i].lead, vecs[i].n_field, vecs[i].n_sent,
                      vecs[i].ck_bad, vecs[i].e_done, vecs[i].e_err, vecs[i].e_words);
        end

        // Framing error inside a frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b0);
        wait_and_check("ferr", 1'b0, 1'b1, 0);
        repeat (CPB * 2) @(negedge clk);

`ifdef ROM_LOADER_CHECKSUM_EN
        exp_q.push_back({ADDR_W'(0), 16'h0005});
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h05, 8'h06};
        send_tx_q();
        wait_and_check("ck_ok", 1'b1, 1'b0, 1);
        exp_q.push_back({ADDR_W'(0), 16'h0005});
        tx_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h05, 8'h07};
        send_tx_q();
        wait_and_check("ck_bad", 1'b0, 1'b1, 1);
`endif

        // Reset in the middle of the second word
        exp_q.push_back({ADDR_W'(0), 16'h1111});
        tx_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h11, 8'h22};
        send_tx_q();
        check("mid_words_before", words_rx, 1);
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rom_load", rom_load, 0);
        check("mid_rst_rom_addr", rom_addr, 0);
        check("mid_rst_rom_data", rom_data, 0);
        check("mid_rst_rom_we", rom_we, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_words", words_rx, 0);
        check("mid_rst_pending", exp_q.size(), 0);
        exp_q.delete();
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB * 2) @(negedge clk);
        run_frame("post_rst", 0, 3, 3, 0, 1'b1, 1'b0, 3);

        // Random frames against the outcome model
        for (int r = 0; r < 6; r++) begin
            nf = $urandom_range(0, MAX_WORDS + 2);
            ns = nf;
            if (nf > 1 && nf <= MAX_WORDS && $urandom_range(0, 3) == 0) ns = nf - $urandom_range(1, nf - 1);
            cb = ($urandom_range(0, 3) == 0);
            model(nf, ns, cb, m_done, m_err, m_words);
            run_frame($sformatf("rnd%0d", r), $urandom_range(0, 2), nf, ns, cb, m_done, m_err, m_words);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
